// File: rtl/axi_traffic_gen.sv
// rtl/axi_traffic_gen.sv - AXI4 write/read-back INCR burst traffic generator and checker; optional counters under TG_LATENCY_EN
package axi_pkg;

    typedef struct packed {
        logic [3:0]  aw_id;
        logic [15:0] aw_addr;
        logic [7:0]  aw_len;
        logic [2:0]  aw_size;
        logic [1:0]  aw_burst;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_last;
        logic        w_valid;
        logic        b_ready;
        logic [3:0]  ar_id;
        logic [15:0] ar_addr;
        logic [7:0]  ar_len;
        logic [2:0]  ar_size;
        logic [1:0]  ar_burst;
        logic        ar_valid;
        logic        r_ready;
    } axi_mosi_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic [3:0]  b_id;
        logic [1:0]  b_resp;
        logic        b_valid;
        logic        ar_ready;
        logic [3:0]  r_id;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
        logic        r_valid;
    } axi_miso_t;

endpackage

module axi_traffic_gen
    import axi_pkg::*;
#(
    parameter logic [3:0] ID         = 4'h0,
    parameter int         MAX_BURSTS = 256,
    localparam int        CNT_W      = $clog2(MAX_BURSTS + 1)
) (
    input  logic             ACLK,
    input  logic             ARESET,
    output axi_mosi_t        m_axi_o,
    input  axi_miso_t        m_axi_i,
    input  logic             start,
    input  logic [15:0]      cfg_addr,
    input  logic [7:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_num,
    input  logic [31:0]      cfg_seed,
    output logic             busy,
    output logic             done,
    output logic [15:0]      err_cnt,
    output logic [31:0]      cyc_total,
    output logic [15:0]      rd_lat_max
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_NEXT,
        S_FIN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      addr_q;
    logic [7:0]       len_q;
    logic [CNT_W-1:0] num_q;
    logic [31:0]      seed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       beat_q;
    logic [1:0]       err_add;
    logic [16:0]      err_sum;
    logic [15:0]      beat_addr;
    logic [31:0]      beat_data;
    logic [15:0]      burst_bytes;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_beat;
    logic             w_hs;
    logic             r_hs;
    logic             start_ok;
    logic             unused_resp;

    // Response codes are not checked; only IDs, data and RLAST framing are.
    assign unused_resp = ^{m_axi_i.b_resp, m_axi_i.r_resp};

    assign beat_addr   = addr_q + {6'd0, beat_q, 2'b00};
    assign beat_data   = seed_q ^ {16'h0000, beat_addr};
    assign burst_bytes = {5'd0, ({1'b0, len_q} + 9'd1), 2'b00};
    assign cnt_inc     = cnt_q + 1'b1;
    assign last_beat   = (beat_q == len_q);
    assign w_hs        = (state_q == S_W) && m_axi_i.w_ready;
    assign r_hs        = (state_q == S_R) && m_axi_i.r_valid;
    assign start_ok    = (state_q == S_IDLE) && start;
    assign busy        = (state_q != S_IDLE);
    assign err_sum     = {1'b0, err_cnt} + {15'd0, err_add};

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, channel outputs and per-handshake error increments.
    always_comb begin
        state_d = state_q;
        m_axi_o = '0;
        err_add = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (cfg_num == '0) ? S_FIN : S_AW;
                end
            end
            S_AW: begin
                m_axi_o.aw_valid = 1'b1;
                m_axi_o.aw_id    = ID;
                m_axi_o.aw_addr  = addr_q;
                m_axi_o.aw_len   = len_q;
                m_axi_o.aw_size  = 3'b010;
                m_axi_o.aw_burst = 2'b01;
                if (m_axi_i.aw_ready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                m_axi_o.w_valid = 1'b1;
                m_axi_o.w_data  = beat_data;
                m_axi_o.w_strb  = 4'hF;
                m_axi_o.w_last  = last_beat;
                if (m_axi_i.w_ready && last_beat) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                m_axi_o.b_ready = 1'b1;
                if (m_axi_i.b_valid) begin
                    err_add = {1'b0, (m_axi_i.b_id != ID)};
                    state_d = S_AR;
                end
            end
            S_AR: begin
                m_axi_o.ar_valid = 1'b1;
                m_axi_o.ar_id    = ID;
                m_axi_o.ar_addr  = addr_q;
                m_axi_o.ar_len   = len_q;
                m_axi_o.ar_size  = 3'b010;
                m_axi_o.ar_burst = 2'b01;
                if (m_axi_i.ar_ready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                m_axi_o.r_ready = 1'b1;
                if (m_axi_i.r_valid) begin
                    err_add = {1'b0, (m_axi_i.r_data != beat_data)}
                            + {1'b0, (m_axi_i.r_id != ID)}
                            + {1'b0, (m_axi_i.r_last != last_beat)};
                    if (last_beat) begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                state_d = (cnt_inc == num_q) ? S_FIN : S_AW;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Configuration capture, burst/beat counters, error count and done pulse.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q  <= 16'h0000;
            len_q   <= 8'h00;
            num_q   <= '0;
            seed_q  <= 32'h0000_0000;
            cnt_q   <= '0;
            beat_q  <= 8'h00;
            err_cnt <= 16'h0000;
            done    <= 1'b0;
        end else begin
            done <= (state_q == S_FIN);
            if (start_ok) begin
                addr_q  <= cfg_addr;
                len_q   <= cfg_len;
                num_q   <= cfg_num;
                seed_q  <= cfg_seed;
                cnt_q   <= '0;
                beat_q  <= 8'h00;
                err_cnt <= 16'h0000;
            end else begin
                if (w_hs || r_hs) begin
                    beat_q <= last_beat ? 8'h00 : beat_q + 8'd1;
                end
                if (state_q == S_NEXT) begin
                    addr_q <= addr_q + burst_bytes;
                    cnt_q  <= cnt_inc;
                end
                if (err_add != 2'd0) begin
                    err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                end
            end
        end
    end

`ifdef TG_LATENCY_EN
    logic [15:0] lat_q;
    logic [15:0] lat_nxt;

    assign lat_nxt = (lat_q == 16'hFFFF) ? 16'hFFFF : lat_q + 16'd1;

    // Busy-cycle total and worst AR-to-first-R latency, both saturating.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cyc_total  <= 32'h0000_0000;
            rd_lat_max <= 16'h0000;
            lat_q      <= 16'h0000;
        end else if (start_ok) begin
            cyc_total  <= 32'h0000_0000;
            rd_lat_max <= 16'h0000;
            lat_q      <= 16'h0000;
        end else begin
            if (busy && (cyc_total != 32'hFFFF_FFFF)) begin
                cyc_total <= cyc_total + 32'd1;
            end
            if ((state_q == S_AR) && m_axi_i.ar_ready) begin
                lat_q <= 16'h0000;
            end else if (state_q == S_R) begin
                lat_q <= lat_nxt;
                if (r_hs && (beat_q == 8'h00) && (lat_nxt > rd_lat_max)) begin
                    rd_lat_max <= lat_nxt;
                end
            end
        end
    end
`else
    assign cyc_total  = 32'h0000_0000;
    assign rd_lat_max = 16'h0000;
`endif

endmodule

// File: doc/axi_traffic_gen.md
# axi_traffic_gen

AXI4 burst traffic generator and checker that drives one slave port of `axi_mux`. It runs a programmed sequence of write-then-read-back INCR bursts, compares read data against a deterministic pattern, and reports errors and status. The block is the stimulus source on each mux input in NoC/PMU cosimulation, replacing external bench-driven masters.

## Interface
- `ID`, default 4'h0: AWID/ARID driven on every transaction; also the expected BID/RID.
- `MAX_BURSTS`, default 256: upper bound on `cfg_num`; sets the burst counter width to $clog2(MAX_BURSTS+1).

Ports:
- `ACLK`  in  1  clock
- `ARESET`  in  1  synchronous, active-high reset
- `m_axi_o`  out  axi_mosi_t  AXI request channels (AW/W/AR, BREADY, RREADY) to the mux slave port
- `m_axi_i`  in  axi_miso_t  AXI responses and readies from the mux
- `start`  in  1  single-cycle pulse; sampled only in IDLE
- `cfg_addr`  in  16  base byte address, word aligned
- `cfg_len`  in  8  AWLEN/ARLEN per burst (beats−1)
- `cfg_num`  in  counter width  number of bursts; 0 means done immediately
- `cfg_seed`  in  32  data pattern seed
- `busy`  out  1  sequence running
- `done`  out  1  one-cycle pulse on completion
- `err_cnt`  out  16  mismatch/protocol error count, saturating at 16'hFFFF
- `cyc_total`  out  32  cycles from start to done (latency feature)
- `rd_lat_max`  out  16  maximum AR-handshake-to-first-R-beat cycles (latency feature)

## Operation
- Configuration is captured on `start` in IDLE. `start` outside IDLE is ignored.
- FSM states: IDLE → AW → W → B → AR → R → NEXT → (AW or FIN) → IDLE.
  - AW: hold AWVALID until AWREADY. AWADDR = current address, AWLEN = cfg_len, AWSIZE = 3'b010, AWBURST = 2'b01.
  - W: send cfg_len+1 beats. WSTRB = 4'hF. WLAST is set on beat cfg_len only. WVALID stays high until the final handshake.
  - B: BREADY = 1. Expect BID == ID; a mismatch adds 1 to err_cnt.
  - AR: same address and length as the AW phase.
  - R: RREADY = 1 for all beats. Each beat is compared with the expected data. Each of these adds 1 to err_cnt:
    - data mismatch
    - RID ≠ ID
    - RLAST asserted on the wrong beat
    - RLAST missing on beat cfg_len
  - R exits on the handshake of beat cfg_len, regardless of RLAST.
  - NEXT: address += (cfg_len+1)*4, modulo 2^16 (natural 16-bit wrap). Burst counter increments. If counter == cfg_num, go to FIN, else go to AW.
  - FIN: pulse `done` for one cycle, then return to IDLE.
- Pattern: beat data = cfg_seed ^ {16'h0, beat_byte_addr}, where beat_byte_addr = burst address + 4*beat (16-bit wrap).
- Only one transaction is outstanding. AW and W are never concurrent. No read is issued before B is received.
- `err_cnt` clears on accepted `start`. It holds its value after done until the next start.
- `busy` = 1 in every state except IDLE.
- cfg_num == 0: the FSM goes IDLE → FIN; `done` pulses 2 cycles after start, and no AXI traffic is issued.

## Timing
- Reset values:
  - all VALIDs = 0, BREADY = RREADY = 0, all payload fields = 0
  - busy = 0, done = 0, err_cnt = 0, cyc_total = 0, rd_lat_max = 0
  - FSM = IDLE
- AWVALID rises the cycle after the `start` sample.
- A handshake completes on a rising edge where VALID && READY.
- The next channel's VALID rises the cycle after the previous handshake.
- VALID and payload are stable while READY is low.
- `done` is registered.
- Reset mid-sequence: all outputs return to reset values on the next edge, and the burst is abandoned. The bench must reset the downstream mux/RAM at the same time.

## Configuration
- `TG_LATENCY_EN` defined:
  - `cyc_total` counts every cycle with busy = 1, saturating at 32'hFFFFFFFF.
  - `rd_lat_max` tracks the max cycles from the AR handshake to the first R handshake, saturating at 16'hFFFF.
  - Both clear on accepted start.
- `TG_LATENCY_EN` undefined: both outputs are tied to 0 and their counters are not synthesized. The port list is unchanged.

## Test plan
- Reset, then start with addr=16'h0100, len=3, num=2, seed=32'hA5A5_0000, into `axi_mux` + `axi_ram` → two write/read pairs at 0x0100 and 0x0110; first WDATA = 32'hA5A5_0100; done pulses; err_cnt = 0.
- Bench corrupts one R beat (XOR 1) in a len=0, num=1 run → err_cnt = 1.
- addr=16'hFFF8, len=3, num=1 → beats at FFF8, FFFC, 0000, 0004; the next burst address wraps to 0x0008; err_cnt = 0.
- cfg_num = 0 → done 2 cycles after start; no AWVALID/ARVALID ever asserted.
- Three generators on mux inputs a/b/c with IDs 1/2/3 and disjoint regions, with random READY stalls → all three finish with err_cnt = 0; VALID and payload are stable under stalls.
- ARESET asserted mid-W-burst → next cycle WVALID = 0, busy = 0. A fresh start after a full reset completes with err_cnt = 0. With `TG_LATENCY_EN`, cyc_total > 0 and rd_lat_max ≥ 1.
